// File: rtl/window_generator_pkg.sv
// window_generator_pkg: shared pixel width, 3x3 window element indices and FSM encoding
package window_generator_pkg;
  localparam int PIX_W = 8;
  localparam int TOP_LEFT  = 0;
  localparam int TOP_MID   = 1;
  localparam int TOP_RIGHT = 2;
  localparam int MID_LEFT  = 3;
  localparam int CENTER    = 4;
  localparam int MID_RIGHT = 5;
  localparam int BOT_LEFT  = 6;
  localparam int BOT_MID   = 7;
  localparam int BOT_RIGHT = 8;
  typedef enum logic {FILL, STREAM} state_t;
endpackage

// File: rtl/window_generator_if.sv
// window_generator_if: pixel stream in, 3x3 window stream out
interface window_generator_if import window_generator_pkg::*; #(parameter int PW = PIX_W);
  logic [PW-1:0]   pixelData;
  logic            pixelValid;
  logic [9*PW-1:0] windowData;
  logic            windowValid;
  logic            frameDone;
  modport master (output pixelData, pixelValid, input windowData, windowValid, frameDone);
  modport slave  (input pixelData, pixelValid, output windowData, windowValid, frameDone);
endinterface

// File: rtl/window_generator_line_buffer.sv
// line_buffer: one image line of pixels, asynchronous read, synchronous write
module line_buffer #(
  parameter int DEPTH = 512,
  parameter int W = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/window_generator.sv
// window_generator: forms 3x3 pixel windows from a raster-order stream using two line buffers
module window_generator import window_generator_pkg::*; #(
  parameter int IMG_WIDTH = 512,
  parameter int IMG_HEIGHT = 512
) (
  input logic clk,
  input logic rst,
  window_generator_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  state_t state, state_nx;
  logic [PIX_W-1:0] top, mid;
  logic [PIX_W-1:0] c0 [3];
  logic [PIX_W-1:0] c1 [3];
  logic [PIX_W-1:0] nc [3];
  logic [9*PIX_W-1:0] win, wdata;
  logic acc, col_last, row_last, emit, wvalid, fdone;
  assign acc = bus.pixelValid;
  assign col_last = col == CW'(IMG_WIDTH - 1);
  assign row_last = row == RW'(IMG_HEIGHT - 1);
  assign emit = acc && state == STREAM && col >= CW'(2);
  assign nc = '{top, mid, bus.pixelData};
  line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) lb0 (
    .clk(clk), .we(acc), .addr(col), .wdata(mid), .rdata(top)
  );
  line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) lb1 (
    .clk(clk), .we(acc), .addr(col), .wdata(bus.pixelData), .rdata(mid)
  );
  always_comb begin
    state_nx = state;
    if (acc && col_last)
      state_nx = state == FILL ? (row == RW'(1) ? STREAM : FILL) : (row_last ? FILL : STREAM);
  end
  always_comb begin
    win = '0;
    win[TOP_LEFT*PIX_W  +: PIX_W] = c0[0];
    win[TOP_MID*PIX_W   +: PIX_W] = c1[0];
    win[TOP_RIGHT*PIX_W +: PIX_W] = nc[0];
    win[MID_LEFT*PIX_W  +: PIX_W] = c0[1];
    win[CENTER*PIX_W    +: PIX_W] = c1[1];
    win[MID_RIGHT*PIX_W +: PIX_W] = nc[1];
    win[BOT_LEFT*PIX_W  +: PIX_W] = c0[2];
    win[BOT_MID*PIX_W   +: PIX_W] = c1[2];
    win[BOT_RIGHT*PIX_W +: PIX_W] = nc[2];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      col    <= '0;
      row    <= '0;
      c0     <= '{default: '0};
      c1     <= '{default: '0};
      wdata  <= '0;
      wvalid <= 1'b0;
      fdone  <= 1'b0;
    end else begin
      state  <= state_nx;
      wvalid <= emit;
      fdone  <= acc && col_last && row_last;
      if (acc) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
        c0 <= c1;
        c1 <= nc;
      end
      if (emit) wdata <= win;
    end
  end
  assign bus.windowData = wdata;
  assign bus.windowValid = wvalid;
  assign bus.frameDone = fdone;
endmodule

// File: tb/tb_window_generator.sv
// tb_window_generator: directed 5x4 frames, gaps, back-to-back frames and mid-frame reset
module tb_window_generator;
  localparam int W = 5;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  int pcnt = 0;
  logic [72:0] got_q[$];
  int pos_q[$];
  window_generator_if #(.PW(8)) bus ();
  window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] ew(input int base, input int k);
    int r, c;
    r = 2 + k / 3;
    c = 2 + k % 3;
    ew = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        ew[(rr*3+cc)*8 +: 8] = 8'(base + (r - 2 + rr) * 16 + (c - 2 + cc));
  endfunction

  always @(posedge clk) begin
    logic pv, rr;
    pv = bus.pixelValid;
    rr = rst;
    #1;
    if (bus.windowValid) begin
      chk("wv_after_idle", 73'(pv), 73'd1);
      got_q.push_back({bus.frameDone, bus.windowData});
      pos_q.push_back(pcnt);
    end
    if (bus.frameDone) chk("fd_with_wv", 73'(bus.windowValid), 73'd1);
    if (rr) pcnt = 0;
    else if (pv) pcnt = (pcnt + 1) % (W * H);
  end

  task automatic beat(input int base, input int r, input int c, input bit gaps);
    if (gaps)
      while ($urandom_range(1) == 1) begin
        @(negedge clk);
        bus.pixelValid = 1'b0;
      end
    @(negedge clk);
    bus.pixelValid = 1'b1;
    bus.pixelData = 8'(base + r * 16 + c);
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        beat(base, r, c, gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pixelValid = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int base, input int first);
    if (got_q.size() >= first + 6)
      for (int k = 0; k < 6; k++) begin
        chk({tag, "_data"}, 73'(got_q[first+k][71:0]), 73'(ew(base, k)));
        chk({tag, "_fd"}, 73'(got_q[first+k][72]), 73'(k == 5));
        chk({tag, "_pos"}, 73'(pos_q[first+k]), 73'((2 + k / 3) * W + 2 + k % 3));
      end
  endtask

  task automatic clear();
    got_q.delete();
    pos_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.pixelValid = 1'b0;
    bus.pixelData = '0;
    repeat (3) @(negedge clk);
    chk("rst_wv", 73'(bus.windowValid), 73'd0);
    chk("rst_fd", 73'(bus.frameDone), 73'd0);
    chk("rst_wd", 73'(bus.windowData), 73'd0);
    rst = 1'b0;
    send_frame(0, 1'b0);
    idle(3);
    chk("t1_count", 73'(got_q.size()), 73'd6);
    if (got_q.size() == 6) begin
      chk("t1_first", 73'(got_q[0][71:0]), 73'(72'h22_21_20_12_11_10_02_01_00));
      chk("t2_last", 73'(got_q[5][71:0]), 73'(72'h34_33_32_24_23_22_14_13_12));
    end
    check_frame("t2", 0, 0);
    clear();
    send_frame(0, 1'b1);
    idle(3);
    chk("t3_count", 73'(got_q.size()), 73'd6);
    check_frame("t3", 0, 0);
    clear();
    send_frame(0, 1'b0);
    send_frame(8'h80, 1'b0);
    idle(3);
    chk("t4_count", 73'(got_q.size()), 73'd12);
    if (got_q.size() == 12)
      chk("t4_first2", 73'(got_q[6][71:0]), 73'(72'hA2_A1_A0_92_91_90_82_81_80));
    check_frame("t4a", 0, 0);
    check_frame("t4b", 8'h80, 6);
    clear();
    for (int i = 0; i < 2 * W + 4; i++) beat(0, i / W, i % W, 1'b0);
    @(negedge clk);
    bus.pixelValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_wv", 73'(bus.windowValid), 73'd0);
    chk("t5_rst_fd", 73'(bus.frameDone), 73'd0);
    clear();
    send_frame(0, 1'b0);
    idle(3);
    chk("t5_count", 73'(got_q.size()), 73'd6);
    check_frame("t5", 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/window_generator.md
Name: window_generator

Overview:
Streaming 3x3 neighbourhood former that sits directly upstream of the convolution filter stage. It accepts one 8-bit greyscale pixel per valid beat in raster order. It keeps two previous image lines in line buffers and emits a packed 72-bit 3x3 window for every pixel position where a full window exists (no border padding). Its output pair windowData/windowValid connects directly to the filter's inputData/inputValid.

Parameters:
IMG_WIDTH, 512, pixels per line; must be >= 3.
IMG_HEIGHT, 512, lines per frame; must be >= 3.
PIX_W, 8, bits per pixel; windowData width is 9*PIX_W.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
pixelData  input  PIX_W  incoming pixel, raster order, top-left first.
pixelValid  input  1  pixelData is valid this cycle; every valid beat is accepted (no backpressure).
windowData  output  9*PIX_W  packed 3x3 window; element i = r*3+c at bits [i*PIX_W +: PIX_W]; r=0 is the oldest line (top), c=0 is the oldest column (left).
windowValid  output  1  windowData holds a complete window this cycle; single-cycle per window.
frameDone  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=1 at clk edge): colCnt=0, rowCnt=0, state=FILL, windowValid=0, frameDone=0, windowData=0, column shift registers=0. Line buffer RAM contents are not cleared; they are don't-care because they are refilled before use. Reset mid-frame abandons the frame, and the next accepted pixel is treated as (0,0).
- Counters: colCnt counts 0..IMG_WIDTH-1 and rowCnt counts 0..IMG_HEIGHT-1. Both advance only on accepted beats. colCnt wraps to 0 and increments rowCnt. At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0.
- Line buffers: lineBuf0 holds row r-2 and lineBuf1 holds row r-1, each IMG_WIDTH x PIX_W, with asynchronous read and synchronous write. On an accepted beat at column c:
  - new column = {lineBuf0[c], lineBuf1[c], pixelData} for top, mid, bottom;
  - then lineBuf0[c] <= lineBuf1[c] and lineBuf1[c] <= pixelData.
- Window register: on an accepted beat the three columns shift left (c0<=c1, c1<=c2, c2<=new column). No shift occurs on idle cycles.
- FSM states:
  - FILL: rowCnt < 2; no windows are emitted. Moves to STREAM on the accepted beat that wraps rowCnt from 1 to 2.
  - STREAM: emits windows. Returns to FILL on the accepted beat at the frame's last pixel.
- Emission: windowValid is asserted the cycle after an accepted beat at (r,c) with state=STREAM and c>=2. That window is centred on pixel (r-1,c-1). Beats at c=0 or c=1 never emit, because those windows would straddle two lines.
- Latency: 1 clock from the accepting pixelValid edge to windowValid/windowData.
- Output count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- Gaps: pixelValid=0 holds all state. windowValid drops to 0 and windowData holds its last value.
- frameDone: asserted the cycle after acceptance of (IMG_HEIGHT-1, IMG_WIDTH-1), together with that beat's windowValid. Back-to-back frames run with no idle cycles required.
- Arithmetic: counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits wide, unsigned. No pixel arithmetic is done here.

Decomposition:
- Shared package: PIX_W, the window element index constants (TOP_LEFT=0 .. BOT_RIGHT=8, CENTER=4), and the FSM state encoding (FILL, STREAM). The downstream filter uses the same index constants.
- One sub-module, line_buffer: an IMG_WIDTH-deep, PIX_W-wide RAM with asynchronous read and synchronous write enable. It is instantiated twice.
- The top level holds the counters, FSM, and column shift registers.

Test Plan:
1. IMG_WIDTH=5, IMG_HEIGHT=4, pixel(r,c)=r*16+c, pixelValid held high -> first windowValid is 1 cycle after the (2,2) beat, with windowData=72'h22_21_20_12_11_10_02_01_00.
2. Same frame -> exactly 6 windows; the last window = 72'h34_33_32_24_23_22_14_13_12; frameDone pulses coincide with that final windowValid.
3. Random pixelValid gaps (~50% duty), same frame -> identical window sequence and values to test 1/2; windowValid never asserted on a cycle after pixelValid=0.
4. Two back-to-back frames, second frame pixel = 0x80+r*16+c -> second frame's first window = 72'hA2_A1_A0_92_91_90_82_81_80; no window mixes frame-1 data.
5. Assert rst after the (2,3) beat, then stream a full frame -> windowValid=0 and frameDone=0 the cycle after reset; the fresh frame yields exactly 6 correct windows.
6. Defaults 512x512 with a ramp image -> 510*510=260100 windows; a scoreboard compares every window against a reference model, with zero mismatches.
